// File: rtl/camera_pkg.sv
// Shared types and default tuning constants for the camera follow controller.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } cam_state_t;

  localparam int DEFAULT_SMOOTH_SHIFT = 3;
  localparam int DEFAULT_DEADZONE     = 16;

endpackage

// File: rtl/camera_axis_step.sv
// One axis of the camera update: error, dead-zone, shifted step with a
// guaranteed minimum of one unit, saturation, and snap-to-target select.
module camera_axis_step #(
  parameter int WORLD_BITS   = 32,
  parameter int SMOOTH_SHIFT = 3,
  parameter int DEADZONE     = 16
) (
  input  logic signed [WORLD_BITS-1:0] cam,
  input  logic signed [WORLD_BITS-1:0] tgt,
  input  logic                         snap,
  output logic signed [WORLD_BITS-1:0] nxt
);

  localparam int W = WORLD_BITS;
  localparam logic signed [W:0]   DZ      = (W+1)'(DEADZONE);
  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  logic signed [W:0]   err;
  logic signed [W:0]   err_abs;
  logic signed [W:0]   step;
  logic signed [W+1:0] sum;

  // NOTE: every variable gets a value before any branch reads it, so no latch is inferred.
  always_comb begin
    err     = {tgt[W-1], tgt} - {cam[W-1], cam};
    err_abs = err[W] ? -err : err;
    step    = err >>> SMOOTH_SHIFT;
    // A small error floors to zero (or stays at -1); force a unit step so the camera converges.
    if (step == '0) step = err[W] ? '1 : (W+1)'(1);
    sum = {cam[W-1], cam[W-1], cam} + {step[W], step};

    if (snap)                 nxt = tgt;
    else if (err_abs <= DZ)   nxt = cam;
    else if (sum > SAT_MAX)   nxt = SAT_MAX[W-1:0];
    else if (sum < SAT_MIN)   nxt = SAT_MIN[W-1:0];
    else                      nxt = sum[W-1:0];
  end

endmodule

// File: rtl/camera_follow.sv
// Per-frame camera position controller: smoothed follow with dead-zone,
// committed once per frame. Define CAMERA_CLAMP_EN to clamp to world bounds.
module camera_follow
  import camera_pkg::*;
#(
  parameter int WORLD_BITS   = 32,
  parameter int SMOOTH_SHIFT = DEFAULT_SMOOTH_SHIFT,
  parameter int DEADZONE     = DEFAULT_DEADZONE,
  parameter logic signed [WORLD_BITS-1:0] INIT_X = '0,
  parameter logic signed [WORLD_BITS-1:0] INIT_Y = '0,
  parameter logic signed [WORLD_BITS-1:0] MIN_X  = WORLD_BITS'(-(2**20)),
  parameter logic signed [WORLD_BITS-1:0] MAX_X  = WORLD_BITS'(2**20),
  parameter logic signed [WORLD_BITS-1:0] MIN_Y  = WORLD_BITS'(-(2**20)),
  parameter logic signed [WORLD_BITS-1:0] MAX_Y  = WORLD_BITS'(2**20)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [WORLD_BITS-1:0] target_x_in,
  input  logic signed [WORLD_BITS-1:0] target_y_in,
  input  logic                         target_valid_in,
  input  logic                         frame_start_in,
  input  logic                         snap_in,
  output logic signed [WORLD_BITS-1:0] camera_x_out,
  output logic signed [WORLD_BITS-1:0] camera_y_out,
  output logic                         camera_valid_out,
  output logic                         busy_out
);

`ifdef CAMERA_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  cam_state_t state, state_n;

  logic signed [WORLD_BITS-1:0] tgt_x, tgt_y;
  logic signed [WORLD_BITS-1:0] snap_tgt_x, snap_tgt_y;
  logic signed [WORLD_BITS-1:0] next_x, next_y;
  logic signed [WORLD_BITS-1:0] step_x, step_y;
  logic                         have_target;
  logic                         snap_pending;
  logic                         snap_rearm;

  function automatic logic signed [WORLD_BITS-1:0] clamp_axis(
    input logic signed [WORLD_BITS-1:0] v,
    input logic signed [WORLD_BITS-1:0] lo,
    input logic signed [WORLD_BITS-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (frame_start_in && (have_target || target_valid_in)) state_n = CALC;
      CALC:    state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy_out = (state != IDLE);

  camera_axis_step #(
    .WORLD_BITS(WORLD_BITS), .SMOOTH_SHIFT(SMOOTH_SHIFT), .DEADZONE(DEADZONE)
  ) u_step_x (
    .cam(camera_x_out), .tgt(snap_tgt_x), .snap(snap_pending), .nxt(step_x)
  );

  camera_axis_step #(
    .WORLD_BITS(WORLD_BITS), .SMOOTH_SHIFT(SMOOTH_SHIFT), .DEADZONE(DEADZONE)
  ) u_step_y (
    .cam(camera_y_out), .tgt(snap_tgt_y), .snap(snap_pending), .nxt(step_y)
  );

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      camera_x_out     <= INIT_X;
      camera_y_out     <= INIT_Y;
      camera_valid_out <= 1'b0;
      tgt_x            <= '0;
      tgt_y            <= '0;
      snap_tgt_x       <= '0;
      snap_tgt_y       <= '0;
      next_x           <= '0;
      next_y           <= '0;
      have_target      <= 1'b0;
      snap_pending     <= 1'b1;
      snap_rearm       <= 1'b0;
    end else begin
      camera_valid_out <= (state == COMMIT);

      if (target_valid_in) begin
        tgt_x       <= target_x_in;
        tgt_y       <= target_y_in;
        have_target <= 1'b1;
      end

      if (state == IDLE && state_n == CALC) begin
        snap_tgt_x <= target_valid_in ? target_x_in : tgt_x;
        snap_tgt_y <= target_valid_in ? target_y_in : tgt_y;
      end

      if (state == CALC) begin
        next_x     <= step_x;
        next_y     <= step_y;
        snap_rearm <= snap_in;
      end

      // A snap requested after CALC sampled the flag survives into the next frame.
      if (state == COMMIT) begin
        camera_x_out <= CLAMP_EN ? clamp_axis(next_x, MIN_X, MAX_X) : next_x;
        camera_y_out <= CLAMP_EN ? clamp_axis(next_y, MIN_Y, MAX_Y) : next_y;
        snap_pending <= snap_in | snap_rearm;
      end else if (snap_in) begin
        snap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_follow.sv
// Self-checking bench for camera_follow: two differently tuned instances share
// stimulus and are compared against a per-frame arithmetic reference model.
module tb_camera_follow;

  localparam longint SMAX = (longint'(1) <<< 31) - 1;
  localparam longint SMIN = -(longint'(1) <<< 31);

  // Tuning of instance 0 (defaults) and instance 1 (fine step, no dead-zone, tight x bounds).
  localparam int     M_SHIFT [2] = '{3, 5};
  localparam int     M_DZ    [2] = '{16, 0};
  localparam longint M_MINX  [2] = '{-(longint'(1) <<< 20), -1000};
  localparam longint M_MAXX  [2] = '{(longint'(1) <<< 20), 1000};
  localparam longint M_MINY  [2] = '{-(longint'(1) <<< 20), -(longint'(1) <<< 20)};
  localparam longint M_MAXY  [2] = '{(longint'(1) <<< 20), (longint'(1) <<< 20)};

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [31:0] target_x_in, target_y_in;
  logic               target_valid_in, frame_start_in, snap_in;
  logic signed [31:0] a_x, a_y, b_x, b_y;
  logic               a_v, a_b, b_v, b_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint m_x [2];
  longint m_y [2];
  longint m_tx, m_ty, st_x, st_y;
  bit     m_have, m_snap, use_snap;

  always #5 clk_in = ~clk_in;

  camera_follow dut_a (
    .clk_in(clk_in), .rst_in(rst_in),
    .target_x_in(target_x_in), .target_y_in(target_y_in),
    .target_valid_in(target_valid_in), .frame_start_in(frame_start_in), .snap_in(snap_in),
    .camera_x_out(a_x), .camera_y_out(a_y), .camera_valid_out(a_v), .busy_out(a_b)
  );

  camera_follow #(
    .SMOOTH_SHIFT(5), .DEADZONE(0), .MIN_X(-1000), .MAX_X(1000)
  ) dut_b (
    .clk_in(clk_in), .rst_in(rst_in),
    .target_x_in(target_x_in), .target_y_in(target_y_in),
    .target_valid_in(target_valid_in), .frame_start_in(frame_start_in), .snap_in(snap_in),
    .camera_x_out(b_x), .camera_y_out(b_y), .camera_valid_out(b_v), .busy_out(b_b)
  );

  function automatic longint axis_next(longint cam, longint tgt, bit snap, int shift, int dz);
    longint err, mag, d, step, n;
    if (snap) return tgt;
    err = tgt - cam;
    mag = (err < 0) ? -err : err;
    if (mag <= dz) return cam;
    d    = longint'(1) << shift;
    step = err / d;
    if (err < 0 && (err % d) != 0) step = step - 1;
    if (step == 0) step = (err > 0) ? 1 : -1;
    n = cam + step;
    if (n > SMAX) n = SMAX;
    if (n < SMIN) n = SMIN;
    return n;
  endfunction

  function automatic longint clamp_m(longint v, longint lo, longint hi);
`ifdef CAMERA_CLAMP_EN
    if (v < lo) return lo;
    if (v > hi) return hi;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_x[d] = 0;
      m_y[d] = 0;
    end
    m_have = 1'b0;
    m_snap = 1'b1;
    m_tx   = 0;
    m_ty   = 0;
  endtask

  task automatic set_target(input int x, input int y);
    @(negedge clk_in);
    target_valid_in = 1'b1;
    target_x_in     = x;
    target_y_in     = y;
    @(negedge clk_in);
    target_valid_in = 1'b0;
    m_have = 1'b1;
    m_tx   = x;
    m_ty   = y;
  endtask

  task automatic request_snap();
    @(negedge clk_in);
    snap_in = 1'b1;
    @(negedge clk_in);
    snap_in = 1'b0;
    m_snap = 1'b1;
  endtask

  // One frame_start pulse; checks busy, hold, commit values and the single valid pulse.
  task automatic run_frame(input string name, input bit coinc, input int cx, input int cy,
                           input bit extra_fs, input bit snap_calc);
    bit fire;
    @(negedge clk_in);
    frame_start_in = 1'b1;
    if (coinc) begin
      target_valid_in = 1'b1;
      target_x_in     = cx;
      target_y_in     = cy;
    end
    fire = m_have || coinc;
    if (coinc) begin
      m_have = 1'b1;
      m_tx   = cx;
      m_ty   = cy;
    end
    st_x     = m_tx;
    st_y     = m_ty;
    use_snap = m_snap;

    @(negedge clk_in);
    frame_start_in  = extra_fs;
    target_valid_in = 1'b0;
    snap_in         = snap_calc;
    checks++;
    if (a_b !== fire || b_b !== fire || a_v !== 1'b0 || b_v !== 1'b0) begin
      failures++;
      $display("FAIL %s busy1: busy=%b/%b valid=%b/%b required busy=%b valid=0",
               name, a_b, b_b, a_v, b_v, fire);
    end

    @(negedge clk_in);
    frame_start_in = 1'b0;
    snap_in        = 1'b0;
    checks++;
    if (a_b !== fire || b_b !== fire || a_v !== 1'b0 || b_v !== 1'b0 ||
        a_x !== 32'(m_x[0]) || a_y !== 32'(m_y[0]) ||
        b_x !== 32'(m_x[1]) || b_y !== 32'(m_y[1])) begin
      failures++;
      $display("FAIL %s hold: busy=%b/%b valid=%b/%b a=(%0d,%0d) b=(%0d,%0d) required busy=%b a=(%0d,%0d) b=(%0d,%0d)",
               name, a_b, b_b, a_v, b_v, a_x, a_y, b_x, b_y, fire, m_x[0], m_y[0], m_x[1], m_y[1]);
    end

    if (fire) begin
      for (int d = 0; d < 2; d++) begin
        m_x[d] = clamp_m(axis_next(m_x[d], st_x, use_snap, M_SHIFT[d], M_DZ[d]), M_MINX[d], M_MAXX[d]);
        m_y[d] = clamp_m(axis_next(m_y[d], st_y, use_snap, M_SHIFT[d], M_DZ[d]), M_MINY[d], M_MAXY[d]);
      end
      m_snap = snap_calc;
    end else begin
      m_snap = m_snap | snap_calc;
    end

    @(negedge clk_in);
    checks++;
    if (a_v !== fire || b_v !== fire || a_b !== 1'b0 || b_b !== 1'b0 ||
        a_x !== 32'(m_x[0]) || a_y !== 32'(m_y[0]) ||
        b_x !== 32'(m_x[1]) || b_y !== 32'(m_y[1])) begin
      failures++;
      $display("FAIL %s commit: valid=%b/%b busy=%b/%b a=(%0d,%0d) b=(%0d,%0d) required valid=%b a=(%0d,%0d) b=(%0d,%0d)",
               name, a_v, b_v, a_b, b_b, a_x, a_y, b_x, b_y, fire, m_x[0], m_y[0], m_x[1], m_y[1]);
    end

    @(negedge clk_in);
    checks++;
    if (a_v !== 1'b0 || b_v !== 1'b0 || a_b !== 1'b0 || b_b !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse_end: valid=%b/%b busy=%b/%b required all 0", name, a_v, b_v, a_b, b_b);
    end
  endtask

  task automatic test_reset();
    rst_in          = 1'b1;
    target_x_in     = '0;
    target_y_in     = '0;
    target_valid_in = 1'b0;
    frame_start_in  = 1'b0;
    snap_in         = 1'b0;
    repeat (2) @(negedge clk_in);
    model_reset();
    checks++;
    if (a_x !== 0 || a_y !== 0 || b_x !== 0 || b_y !== 0 ||
        a_v !== 1'b0 || b_v !== 1'b0 || a_b !== 1'b0 || b_b !== 1'b0) begin
      failures++;
      $display("FAIL reset: a=(%0d,%0d) b=(%0d,%0d) valid=%b/%b busy=%b/%b required zeros",
               a_x, a_y, b_x, b_y, a_v, b_v, a_b, b_b);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_no_target();
    run_frame("no_target", 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_snap();
    set_target(1000, -500);
    run_frame("snap", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== 1000 || a_y !== -500) begin
      failures++;
      $display("FAIL snap_value: got (%0d,%0d) required (1000,-500)", a_x, a_y);
    end
  endtask

  task automatic test_smoothing();
    set_target(0, 0);
    request_snap();
    run_frame("smooth_snap0", 1'b0, 0, 0, 1'b0, 1'b0);
    set_target(800, 0);
    run_frame("smooth_f1", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== 100 || a_y !== 0) begin
      failures++;
      $display("FAIL smooth_f1_value: got (%0d,%0d) required (100,0)", a_x, a_y);
    end
    run_frame("smooth_f2", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== 187 || a_y !== 0) begin
      failures++;
      $display("FAIL smooth_f2_value: got (%0d,%0d) required (187,0)", a_x, a_y);
    end
  endtask

  task automatic test_deadzone();
    set_target(0, 0);
    request_snap();
    run_frame("dz_snap0", 1'b0, 0, 0, 1'b0, 1'b0);
    set_target(10, 0);
    run_frame("dz_in", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== 0) begin
      failures++;
      $display("FAIL dz_in_value: got %0d required 0", a_x);
    end
    set_target(-17, 0);
    run_frame("dz_out", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== -3) begin
      failures++;
      $display("FAIL dz_out_value: got %0d required -3", a_x);
    end
    set_target(0, 0);
    request_snap();
    run_frame("minstep_snap0", 1'b0, 0, 0, 1'b0, 1'b0);
    set_target(20, 0);
    run_frame("minstep", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (b_x !== 1 || a_x !== 2) begin
      failures++;
      $display("FAIL minstep_value: got b=%0d a=%0d required b=1 a=2", b_x, a_x);
    end
  endtask

  task automatic test_clamp();
    int exp_b;
`ifdef CAMERA_CLAMP_EN
    exp_b = 1000;
`else
    exp_b = 5000;
`endif
    set_target(5000, 0);
    request_snap();
    run_frame("clamp", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (b_x !== exp_b || a_x !== 5000) begin
      failures++;
      $display("FAIL clamp_value: got b=%0d a=%0d required b=%0d a=5000", b_x, a_x, exp_b);
    end
  endtask

  task automatic test_edge_cases();
    request_snap();
    // Coincident target, a second frame_start in CALC, and a snap in CALC.
    run_frame("coinc", 1'b1, 300, 300, 1'b1, 1'b1);
    checks++;
    if (a_x !== 300 || a_y !== 300 || b_x !== 300 || b_y !== 300) begin
      failures++;
      $display("FAIL coinc_value: a=(%0d,%0d) b=(%0d,%0d) required all 300", a_x, a_y, b_x, b_y);
    end
    set_target(-2000, 50);
    run_frame("late_snap", 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (a_x !== -2000 || a_y !== 50) begin
      failures++;
      $display("FAIL late_snap_value: got (%0d,%0d) required (-2000,50)", a_x, a_y);
    end

    set_target(700, -700);
    @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    checks++;
    if (a_b !== 1'b1 || b_b !== 1'b1) begin
      failures++;
      $display("FAIL rst_calc_busy: busy=%b/%b required 1", a_b, b_b);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    model_reset();
    checks++;
    if (a_x !== 0 || a_y !== 0 || b_x !== 0 || b_y !== 0 ||
        a_v !== 1'b0 || b_v !== 1'b0 || a_b !== 1'b0 || b_b !== 1'b0) begin
      failures++;
      $display("FAIL rst_calc: a=(%0d,%0d) b=(%0d,%0d) valid=%b/%b busy=%b/%b required zeros",
               a_x, a_y, b_x, b_y, a_v, b_v, a_b, b_b);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if (a_v !== 1'b0 || b_v !== 1'b0 || a_x !== 0 || b_x !== 0) begin
        failures++;
        $display("FAIL rst_after_%0d: valid=%b/%b x=%0d/%0d required 0", i, a_v, b_v, a_x, b_x);
      end
    end
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) != 0) begin
        if ($urandom_range(7) == 0) begin
          x = int'($urandom);
          y = int'($urandom);
        end else begin
          x = int'($urandom_range(8000)) - 4000;
          y = int'($urandom_range(8000)) - 4000;
        end
        set_target(x, y);
      end
      if ($urandom_range(3) == 0) request_snap();
      repeat ($urandom_range(2)) @(negedge clk_in);
      x = int'($urandom_range(8000)) - 4000;
      y = int'($urandom_range(8000)) - 4000;
      run_frame($sformatf("rand%0d", i), ($urandom_range(4) == 0), x, y,
                ($urandom_range(1) == 1), ($urandom_range(5) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_no_target();
    test_snap();
    test_smoothing();
    test_deadzone();
    test_clamp();
    test_edge_cases();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/camera_follow.md
# camera_follow

Per-frame camera position controller. Tracks the car's world position and produces the `camera_x`/`camera_y` pair consumed by the pixel-to-world mapping stage. Uses exponential smoothing with a dead-zone, optionally clamped to world bounds. Outputs change only once per frame, at a frame-start pulse, so the camera never moves mid-scan.

## Interface
- `WORLD_BITS`, 32, width of all signed world coordinates
- `SMOOTH_SHIFT`, 3, step = error >>> SMOOTH_SHIFT
- `DEADZONE`, 16, |error| ≤ DEADZONE → no motion on that axis
- `INIT_X`, `INIT_Y`, 0, reset camera position
- `MIN_X`, `MAX_X`, `MIN_Y`, `MAX_Y`, -2^20 / 2^20, clamp bounds (used only with clamp macro)

Ports:
- `clk_in` in 1 — pixel clock
- `rst_in` in 1 — synchronous, active-high reset
- `target_x_in`, `target_y_in` in WORLD_BITS signed — car position
- `target_valid_in` in 1 — target sample strobe
- `frame_start_in` in 1 — one-cycle pulse at start of vertical blanking
- `snap_in` in 1 — request jump-to-target on next update
- `camera_x_out`, `camera_y_out` out WORLD_BITS signed — camera position, registered
- `camera_valid_out` out 1 — one-cycle pulse when new camera values commit
- `busy_out` out 1 — high in CALC and COMMIT

## Operation
- Target latch: `target_valid_in` captures the inputs into `tgt_x`/`tgt_y` and sets `have_target`. This happens in any state.
- `snap_pending` is set by reset and by `snap_in`. It is cleared on COMMIT.
- FSM states: IDLE, CALC, COMMIT.
- IDLE:
  - If `frame_start_in` && `have_target`: snapshot the target into `snap_tgt`, then go to CALC.
  - If `target_valid_in` is high in the same cycle, the incoming values win.
  - If there is no target, stay in IDLE and emit no valid pulse.
- CALC (one cycle, per axis, in parallel):
  - `err = snap_tgt - cam`, computed at WORLD_BITS+1 signed.
  - If `snap_pending`: `next = snap_tgt`.
  - Else if |err| ≤ DEADZONE: `next = cam`.
  - Else `step = err >>> SMOOTH_SHIFT` (arithmetic, floor). If step == 0, use step = sign(err) to guarantee convergence.
  - `next = cam + step`, saturated to the WORLD_BITS signed range.
  - Register `next_x`/`next_y`, then go to COMMIT.
- COMMIT: `camera_*_out` <= clamp(`next_*`); `camera_valid_out` <= 1; clear `snap_pending`; go to IDLE.
- `frame_start_in` while busy is ignored.
- A `snap_in` arriving during CALC applies to the next frame.

## Timing
- Reset values: `camera_x_out` = INIT_X, `camera_y_out` = INIT_Y, `camera_valid_out` = 0, `busy_out` = 0, state IDLE, `have_target` = 0, `snap_pending` = 1.
- Latency: frame_start is sampled at edge E. CALC is entered after E. Outputs update at edge E+2, and `camera_valid_out` is high for exactly the cycle following E+2.
- `busy_out` is high for the two cycles following E.
- Outputs hold constant between commits.
- Reset mid-operation aborts the update: outputs return to INIT at the reset edge, with no valid pulse.

## Configuration
- Macro `CAMERA_CLAMP_EN`.
- Defined: the committed value is clamped to [MIN_X, MAX_X] / [MIN_Y, MAX_Y], snap included.
- Undefined: no clamp; only the WORLD_BITS saturation applies.

## Structure
- Package `camera_pkg`:
  - `cam_state_t` enum (IDLE, CALC, COMMIT).
  - Default SMOOTH_SHIFT and DEADZONE constants.
- Sub-module `camera_axis_step`:
  - Combinational per-axis logic: error, dead-zone, shift, min-step, saturate, snap select.
  - Instantiated twice (x, y).
  - Clamp lives in the parent, under the macro.

## Test plan
- Reset, no target, `frame_start_in` pulse → no valid pulse; outputs stay (0,0); `busy_out` stays 0.
- Target (1000,-500), then frame_start → snap: outputs (1000,-500) at E+2, one-cycle valid pulse.
- Snap to (0,0), then target (800,0), 2 frames, SHIFT=3, DZ=16 → x = 100, then 187; y = 0.
- Dead-zone test from cam 0:
  - Target x = 10 → x stays 0.
  - Then target x = -17 → x = -3.
  - Target x = 20 with DEADZONE = 0, SHIFT = 5 → x = 1 (min step).
- Clamp test, MAX_X = 1000, snap to 5000:
  - With `CAMERA_CLAMP_EN` → 1000.
  - Without → 5000.
- Edge-case sequence:
  - `target_valid_in` (300,300) coincident with frame_start, after snap → snap commits (300,300).
  - A second frame_start during CALC is ignored: one valid pulse only.
  - `rst_in` asserted in CALC → outputs INIT, no valid pulse.
